gpio_bus_master: RTL

GPIO_BUS_MASTER -- requirements
Module: gpio_bus_master

---
 rtl/gpio_bus_master_pkg.sv | 24 ++
 rtl/gpio_poll_timer.sv | 36 +++
 rtl/gpio_bus_master.sv | 106 ++++++++++
 3 files changed

// File: rtl/gpio_bus_master_pkg.sv
// Shared definitions for the GPIO bus master: bus address map, FSM encoding,
// and the captured command record.
package gpio_bus_master_pkg;

  localparam logic [1:0] GPI1 = 2'd0;
  localparam logic [1:0] GPI2 = 2'd1;
  localparam logic [1:0] GPO1 = 2'd2;
  localparam logic [1:0] GPO2 = 2'd3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD_BUS = 3'd1,
    RESP    = 3'd2,
    POLL_RD = 3'd3,
    POLL_WR = 3'd4
  } state_t;

  typedef struct packed {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
  } cmd_t;

endpackage

// File: rtl/gpio_poll_timer.sv
// Free-running poll interval counter; raises a sticky pending flag on each
// expiry until the master starts servicing it.
module gpio_poll_timer #(
  parameter int unsigned POLL_PERIOD = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic pending
);

  localparam logic [15:0] LAST = 16'(POLL_PERIOD - 1);

  logic [15:0] cnt;
  logic        expire;

  assign expire = en && (cnt == LAST);

  // A fresh expiry in the same cycle the poll starts keeps the flag set,
  // so that interval is not lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      pending <= 1'b0;
    end else begin
      if (!en || expire) cnt <= '0;
      else               cnt <= cnt + 16'd1;

      if (!en)         pending <= 1'b0;
      else if (expire) pending <= 1'b1;
      else if (clr)    pending <= 1'b0;
    end
  end

endmodule

// File: rtl/gpio_bus_master.sv
// Single-master bus front end: serves host read/write commands and, between
// them, periodically polls one GPIO input and mirrors changes to an output.
module gpio_bus_master
  import gpio_bus_master_pkg::*;
#(
  parameter int unsigned POLL_PERIOD = 1000,
  parameter logic [1:0]  POLL_SRC    = GPI1,
  parameter logic [1:0]  POLL_DST    = GPO1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [1:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  input  logic        poll_en,
  output logic        change_irq,
  output logic [1:0]  A,
  output logic        WE,
  output logic [31:0] WD,
  input  logic [31:0] RD
);

  state_t      state, nxt;
  logic        rdy_q;
  cmd_t        cmd_q;
  logic [31:0] rdata_q;
  logic [31:0] last_sample;
  logic        pending;
  logic        accept;
  logic        start_poll;
  logic        changed;

  gpio_poll_timer #(.POLL_PERIOD(POLL_PERIOD)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .en      (poll_en),
    .clr     (start_poll),
    .pending (pending)
  );

  // A pending poll only takes the bus when no command is offered this cycle.
  assign cmd_ready  = rdy_q && (state == IDLE) && (cmd_valid || !pending);
  assign accept     = cmd_valid && cmd_ready;
  assign start_poll = rdy_q && (state == IDLE) && pending && !cmd_valid;
  assign changed    = (RD != last_sample);

  assign rsp_valid  = (state == RESP);
  assign rsp_rdata  = rdata_q;
  assign change_irq = (state == POLL_WR);

  always_comb begin
    nxt = state;
    A   = '0;
    WE  = 1'b0;
    WD  = '0;
    unique case (state)
      IDLE: begin
        if (accept)          nxt = CMD_BUS;
        else if (start_poll) nxt = POLL_RD;
      end
      CMD_BUS: begin
        A   = cmd_q.addr;
        WE  = cmd_q.wr;
        WD  = cmd_q.wdata;
        nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) nxt = IDLE;
      end
      POLL_RD: begin
        A   = POLL_SRC;
        nxt = changed ? POLL_WR : IDLE;
      end
      POLL_WR: begin
        A   = POLL_DST;
        WE  = 1'b1;
        WD  = last_sample;
        nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      rdy_q       <= 1'b0;
      cmd_q       <= '0;
      rdata_q     <= '0;
      last_sample <= '0;
    end else begin
      state <= nxt;
      rdy_q <= 1'b1;
      if (accept) cmd_q <= '{wr: cmd_wr, addr: cmd_addr, wdata: cmd_wdata};
      if (state == CMD_BUS) rdata_q <= cmd_q.wr ? 32'd0 : RD;
      // last_sample doubles as the write data for the following POLL_WR.
      if (state == POLL_RD && changed) last_sample <= RD;
    end
  end

endmodule
